// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: shared entry/exit barrier controller with four-slot
// occupancy tracking and status fields for the seven-segment display.
// Optional build macro PARK_GATE_TIMEOUT_EN enables the OPEN timeout counter;
// without it the gate waits in OPEN until the car clears the sensor.
module parking_gate_ctrl #(
  parameter int OPEN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic       pass,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       gate_open,
  output logic       full,
  output logic [1:0] L,
  output logic [2:0] c,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_OPEN, ST_CLOSE} state_t;

  state_t     r_state;
  logic [3:0] r_occ;
  logic       r_pend_exit;
  logic [1:0] r_pend_slot;
  logic       r_last_exit;
  logic       r_entry_ack;
  logic       r_exit_ack;
  logic       r_gate_open;
  logic       r_full;
  logic [1:0] r_L;
  logic [2:0] r_c;
  logic       r_err;

`ifdef PARK_GATE_TIMEOUT_EN
  localparam int CNT_W = $clog2(OPEN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPEN_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
`else
  // Without the timeout the gate-open length is irrelevant; nothing is built.
  generate
    if (OPEN_CYCLES < 2) begin : g_open_cycles_ignored
    end
  endgenerate
`endif

  logic       w_entry_elig;
  logic       w_pick_exit;
  logic       w_any_elig;
  logic       w_commit;
  logic [1:0] w_free_slot;
  logic [3:0] w_occ_next;
  logic [2:0] w_used_cnt;
  logic [2:0] w_free_cnt;

  // An entry only competes while a slot is free; a tie goes to the side not served last.
  assign w_entry_elig = entry_req & ~r_full;
  assign w_any_elig   = exit_req | w_entry_elig;
  assign w_pick_exit  = exit_req & (~w_entry_elig | ~r_last_exit);
  assign w_commit     = (r_state == ST_OPEN) & pass;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    w_free_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_occ[i]) w_free_slot = 2'(i);
    end
  end

  // Bitmap after a committed pass: entry occupies the slot, exit frees it.
  always_comb begin
    w_occ_next = r_occ;
    if (w_commit) w_occ_next[r_pend_slot] = ~r_pend_exit;
  end

  assign w_used_cnt = 3'(w_occ_next[0]) + 3'(w_occ_next[1]) +
                      3'(w_occ_next[2]) + 3'(w_occ_next[3]);
  assign w_free_cnt = 3'd4 - w_used_cnt;

  // Gate sequencing FSM with registered acks, gate drive and status fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_occ       <= 4'd0;
      r_pend_exit <= 1'b0;
      r_pend_slot <= 2'd0;
      r_last_exit <= 1'b0;
      r_entry_ack <= 1'b0;
      r_exit_ack  <= 1'b0;
      r_gate_open <= 1'b0;
      r_full      <= 1'b0;
      r_L         <= 2'd0;
      r_c         <= 3'd4;
      r_err       <= 1'b0;
`ifdef PARK_GATE_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_entry_ack <= 1'b0;
      r_exit_ack  <= 1'b0;
      r_err       <= 1'b0;
      // Status fields track the bitmap so they change together with the commit.
      r_occ  <= w_occ_next;
      r_c    <= w_free_cnt;
      r_full <= &w_occ_next;
      if (w_commit && !r_pend_exit) r_L <= r_pend_slot;

      case (r_state)
        ST_IDLE: begin
          if (w_any_elig) begin
            r_state     <= ST_GRANT;
            r_pend_exit <= w_pick_exit;
            if (w_pick_exit) begin
              r_pend_slot <= exit_slot;
              r_exit_ack  <= 1'b1;
              // Error is decided here so it pulses together with the ack.
              r_err       <= ~r_occ[exit_slot];
            end else begin
              r_pend_slot <= w_free_slot;
              r_entry_ack <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          r_last_exit <= r_pend_exit;
          if (r_pend_exit && !r_occ[r_pend_slot]) begin
            r_state <= ST_IDLE;
          end else begin
            r_state     <= ST_OPEN;
            r_gate_open <= 1'b1;
`ifdef PARK_GATE_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        ST_OPEN: begin
          if (pass) begin
            r_state     <= ST_CLOSE;
            r_gate_open <= 1'b0;
          end
`ifdef PARK_GATE_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_CLOSE;
            r_gate_open <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_CLOSE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign entry_ack = r_entry_ack;
  assign exit_ack  = r_exit_ack;
  assign gate_open = r_gate_open;
  assign full      = r_full;
  assign L         = r_L;
  assign c         = r_c;
  assign err       = r_err;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: table-driven directed vectors for parking_gate_ctrl,
// plus hand-written timeout and mid-OPEN reset sequences.
module tb_parking_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       pass;
  logic       entry_ack;
  logic       exit_ack;
  logic       gate_open;
  logic       full;
  logic [1:0] L;
  logic [2:0] c;
  logic       err;

  int n_checks;
  int n_errors;

  parking_gate_ctrl #(.OPEN_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .exit_slot (exit_slot),
    .pass      (pass),
    .entry_ack (entry_ack),
    .exit_ack  (exit_ack),
    .gate_open (gate_open),
    .full      (full),
    .L         (L),
    .c         (c),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs already set, output sample 1 time unit after the edge.
  typedef struct packed {
    logic       rst;
    logic       ereq;
    logic       xreq;
    logic [1:0] slot;
    logic       pass;
    logic       e_ack;
    logic       x_ack;
    logic       gate;
    logic       full;
    logic [1:0] l;
    logic [2:0] c;
    logic       err;
  } vec_t;

  vec_t vq[$];

  function automatic void v(input logic r, input logic er, input logic xr,
                            input logic [1:0] sl, input logic ps,
                            input logic ea, input logic xa, input logic g,
                            input logic f, input logic [1:0] l,
                            input logic [2:0] cc, input logic e);
    vec_t t;
    t = '{r, er, xr, sl, ps, ea, xa, g, f, l, cc, e};
    vq.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_entry();
    entry_req = 1'b1; tick();
    entry_req = 1'b0; tick();
    pass = 1'b1;      tick();
    pass = 1'b0;      tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] act_o;
    logic [10:0] exp_o;
    int          n_high;
    logic [1:0]  lp;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0; pass = 1'b0;

    // ---- Reset, then four entries fill slots 0..3 ----
    v(1,0,0,0,0, 0,0,0,0,2'd0,3'd4,0);
    for (int i = 0; i < 4; i++) begin
      lp = (i == 0) ? 2'd0 : 2'(i - 1);
      v(0,1,0,0,0, 1,0,0,0, lp, 3'(4 - i), 0);   // grant
      v(0,0,0,0,0, 0,0,1,0, lp, 3'(4 - i), 0);   // gate opens
      v(0,0,0,0,0, 0,0,1,0, lp, 3'(4 - i), 0);   // waiting for car
      v(0,0,0,0,1, 0,0,0, (i == 3), 2'(i), 3'(3 - i), 0); // commit
      v(0,0,0,0,0, 0,0,0, (i == 3), 2'(i), 3'(3 - i), 0); // back to idle
    end
    // ---- Full: entry waits, exit of slot 2, then entry gets slot 2 ----
    v(0,1,0,0,0, 0,0,0,1,2'd3,3'd0,0);
    v(0,1,0,0,0, 0,0,0,1,2'd3,3'd0,0);
    v(0,1,1,2,0, 0,1,0,1,2'd3,3'd0,0);
    v(0,1,0,0,0, 0,0,1,1,2'd3,3'd0,0);
    v(0,1,0,0,1, 0,0,0,0,2'd3,3'd1,0);
    v(0,1,0,0,0, 0,0,0,0,2'd3,3'd1,0);
    v(0,1,0,0,0, 1,0,0,0,2'd3,3'd1,0);
    v(0,0,0,0,0, 0,0,1,0,2'd3,3'd1,0);
    v(0,0,0,0,1, 0,0,0,1,2'd2,3'd0,0);
    v(0,0,0,0,0, 0,0,0,1,2'd2,3'd0,0);
    // ---- Reset, occupy slot 0 with a minimum transaction ----
    v(1,0,0,0,0, 0,0,0,0,2'd0,3'd4,0);
    v(0,1,0,0,0, 1,0,0,0,2'd0,3'd4,0);
    v(0,0,0,0,0, 0,0,1,0,2'd0,3'd4,0);
    v(0,0,0,0,1, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,0,0,0, 0,0,0,0,2'd0,3'd3,0);
    // ---- Tie: exit wins first, the next tie goes to entry ----
    v(0,1,1,0,0, 0,1,0,0,2'd0,3'd3,0);
    v(0,1,0,0,0, 0,0,1,0,2'd0,3'd3,0);
    v(0,1,0,0,1, 0,0,0,0,2'd0,3'd4,0);
    v(0,1,0,0,0, 0,0,0,0,2'd0,3'd4,0);
    v(0,1,1,0,0, 1,0,0,0,2'd0,3'd4,0);
    v(0,0,1,0,0, 0,0,1,0,2'd0,3'd4,0);
    v(0,0,1,0,1, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,1,0,0, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,1,0,0, 0,1,0,0,2'd0,3'd3,0);
    v(0,0,0,0,0, 0,0,1,0,2'd0,3'd3,0);
    v(0,0,0,0,1, 0,0,0,0,2'd0,3'd4,0);
    v(0,0,0,0,0, 0,0,0,0,2'd0,3'd4,0);
    // ---- Occupy slot 0, then exit of free slot 3 errors ----
    v(0,1,0,0,0, 1,0,0,0,2'd0,3'd4,0);
    v(0,0,0,0,0, 0,0,1,0,2'd0,3'd4,0);
    v(0,0,0,0,1, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,0,0,0, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,1,3,0, 0,1,0,0,2'd0,3'd3,1);
    v(0,0,0,0,0, 0,0,0,0,2'd0,3'd3,0);
    v(0,0,0,0,1, 0,0,0,0,2'd0,3'd3,0);  // pass outside OPEN ignored
    v(0,0,0,0,0, 0,0,0,0,2'd0,3'd3,0);

    foreach (vq[k]) begin
      rst       = vq[k].rst;
      entry_req = vq[k].ereq;
      exit_req  = vq[k].xreq;
      exit_slot = vq[k].slot;
      pass      = vq[k].pass;
      tick();
      act_o = {entry_ack, exit_ack, gate_open, full, L, c, err};
      exp_o = {vq[k].e_ack, vq[k].x_ack, vq[k].gate, vq[k].full, vq[k].l, vq[k].c, vq[k].err};
      $display("vec %0d: in rst=%b er=%b xr=%b slot=%0d pass=%b out ea=%b xa=%b gate=%b full=%b L=%0d c=%0d err=%b",
               k, rst, entry_req, exit_req, exit_slot, pass,
               entry_ack, exit_ack, gate_open, full, L, c, err);
      chk($sformatf("vec%0d", k), 32'(act_o), 32'(exp_o));
    end
    rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0; pass = 1'b0;

    // ---- Gate held open with no pass ----
    rst = 1'b1; tick();
    rst = 1'b0;
    entry_req = 1'b1; tick();
    chk("timeout_ack", 32'(entry_ack), 32'd1);
    entry_req = 1'b0; tick();
`ifdef PARK_GATE_TIMEOUT_EN
    n_high = 0;
    for (int i = 0; i < 40; i++) begin
      if (!gate_open) break;
      n_high++;
      tick();
    end
    $display("timeout: gate high for %0d cycles", n_high);
    chk("timeout_len", 32'(n_high), 32'd16);
    chk("timeout_c", 32'(c), 32'd4);
    chk("timeout_L", 32'(L), 32'd0);
    chk("timeout_full", 32'(full), 32'd0);
`else
    repeat (100) tick();
    $display("no-timeout: gate=%b after 100 cycles", gate_open);
    chk("hold_gate", 32'(gate_open), 32'd1);
    chk("hold_c", 32'(c), 32'd4);
    pass = 1'b1; tick();
    pass = 1'b0;
    chk("hold_close", 32'(gate_open), 32'd0);
    chk("hold_commit_c", 32'(c), 32'd3);
    tick();
`endif

    // ---- Reset in the middle of OPEN with two slots occupied ----
    rst = 1'b1; tick();
    rst = 1'b0;
    do_entry();
    do_entry();
    chk("pre_rst_L", 32'(L), 32'd1);
    entry_req = 1'b1; tick();
    entry_req = 1'b0; tick();
    chk("pre_rst_gate", 32'(gate_open), 32'd1);
    chk("pre_rst_c", 32'(c), 32'd2);
    rst = 1'b1; tick();
    rst = 1'b0;
    $display("reset mid-open: gate=%b c=%0d full=%b L=%0d", gate_open, c, full, L);
    chk("rst_gate", 32'(gate_open), 32'd0);
    chk("rst_c", 32'(c), 32'd4);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_L", 32'(L), 32'd0);
    entry_req = 1'b1; tick();
    entry_req = 1'b0;
    chk("rst_idle_grant", 32'(entry_ack), 32'd1);
    tick();
    pass = 1'b1; tick();
    pass = 1'b0;
    chk("rst_reentry_L", 32'(L), 32'd0);
    chk("rst_reentry_c", 32'(c), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Occupancy and gate controller for the parking lot. It shares a single barrier between the entry and exit sensors, allocates and frees the four parking slots, and produces the `full` / `L` / `c` status fields consumed by the seven-segment display driver. It sits between the sensor/debounce logic and the display and barrier actuator.

## Interface
Parameters:
- `OPEN_CYCLES`, default 16: gate-open timeout in clk cycles (≥2); counter width is `$clog2(OPEN_CYCLES+1)`.

Ports:
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `entry_req`  in  1  car waiting at entry; level, held until `entry_ack`
- `exit_req`  in  1  car waiting at exit; level, held until `exit_ack`
- `exit_slot`  in  2  slot being vacated; valid while `exit_req`=1
- `pass`  in  1  car has cleared the barrier sensor (single-cycle pulse)
- `entry_ack`  out  1  one-cycle grant pulse to the entry requester
- `exit_ack`  out  1  one-cycle grant pulse to the exit requester
- `gate_open`  out  1  barrier actuator; 1 = open
- `full`  out  1  no free slot
- `L`  out  2  index of the slot assigned by the last committed entry
- `c`  out  3  free-slot count, 0..4
- `err`  out  1  one-cycle pulse: exit requested for an already-free slot

## Operation
- State: `occ[3:0]` slot bitmap (1 = occupied), `pend_dir` (entry/exit), `pend_slot[1:0]`, `last_exit` round-robin flag, timeout counter.
- FSM states: IDLE, GRANT, OPEN, CLOSE.
- IDLE: eligible = `exit_req` | (`entry_req` & !`full`). If none is eligible, stay in IDLE. If only one is eligible, grant it. If both are eligible, grant the side not served last; after reset, exit wins. Go to GRANT and latch `pend_dir`/`pend_slot`.
  - Entry `pend_slot` = lowest-index zero bit of `occ`.
  - Exit `pend_slot` = `exit_slot`.
- GRANT (1 cycle): the matching ack = 1 and `last_exit` is updated.
  - Exit with `occ[pend_slot]`=0: `err`=1, go to IDLE, gate stays closed.
  - Otherwise go to OPEN and clear the counter.
- OPEN: `gate_open`=1 and the counter increments.
  - On `pass`=1: commit. Entry sets `occ[pend_slot]` and `L`←`pend_slot`; exit clears `occ[pend_slot]`. Then go to CLOSE.
  - On timeout (see Configuration): go to CLOSE with no commit.
- CLOSE (1 cycle): `gate_open`=0, then go to IDLE.
- `c` = 4 − popcount(`occ`), registered and updated the cycle after the commit. `full` = (`occ`==4'b1111), registered alongside `c`.
- `entry_req` while `full`=1 stays pending and unacked; it is served once an exit commits.
- `pass` outside OPEN is ignored.
- Any `rst`=1 cycle, including mid-OPEN, clears everything. Reset values:
  - State: IDLE; `occ`=0.
  - Outputs: `gate_open`=0, acks=0, `err`=0, `full`=0, `L`=0, `c`=4.

## Timing
- Request seen at edge t (state IDLE) → ack high during cycle t+1 → `gate_open` high from t+2.
- `pass` sampled at edge p → `gate_open`=0 from p+1 (CLOSE). Updated `occ`, `c`, `full`, `L` are visible from p+1. Earliest next grant is at p+2 (IDLE sample), with ack at p+3.
- Timeout: `gate_open` is high for exactly `OPEN_CYCLES` cycles when no `pass` arrives.
- `pass` arriving in the same cycle the counter reaches `OPEN_CYCLES`−1: `pass` wins and the transaction commits.
- Minimum transaction: 4 cycles (IDLE, GRANT, OPEN with immediate pass, CLOSE).
- Error transaction: 2 cycles, with no gate activity.

## Configuration
- `PARK_GATE_TIMEOUT_EN` defined: the OPEN timeout is active. After `OPEN_CYCLES` cycles without `pass`, go to CLOSE with no commit and no status change.
- Not defined: the counter and its compare are not synthesized; OPEN waits indefinitely for `pass`. `OPEN_CYCLES` is then unused.

## Test plan
- Reset, then 4 entries, each with `pass` 1 cycle after `gate_open` → `L`=0,1,2,3 in order; `c`=3,2,1,0; `full`=1 after the 4th commit.
- `full`=1 with `entry_req` held, then `exit_req` with `exit_slot`=2 and `pass` → exit commits, `c`=1, `full`=0. Entry is then granted and gets slot 2 (`L`=2), leaving `c`=0.
- `entry_req` and `exit_req` asserted in the same cycle from IDLE with slot 0 occupied → `exit_ack` first, `entry_ack` on the next transaction; a repeat tie alternates.
- `exit_req` with `exit_slot`=3 while `occ[3]`=0 → `exit_ack` and `err` pulse in the same cycle, `gate_open` never rises, `c` is unchanged.
- With `PARK_GATE_TIMEOUT_EN` and `OPEN_CYCLES`=16, entry granted and no `pass` → `gate_open` high for exactly 16 cycles, `c`/`L` unchanged; without the macro, `gate_open` is still high after 100 cycles.
- `rst` asserted during OPEN with 2 slots occupied → next cycle `gate_open`=0, `c`=4, `full`=0, `L`=0, state IDLE.
